riscv_dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the core's load/store port, serving MEM-stage requests.

---
 rtl/riscv_dmem_responder_if.sv | 24 ++
 rtl/riscv_dmem_responder.sv | 157 +++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
interface riscv_dmem_responder_if #(
    parameter int XLEN = 32
);
    logic            req_i;
    logic            we_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] wdata_i;
    logic            gnt_o;
    logic            rvalid_o;
    logic [XLEN-1:0] rdata_o;
    logic            err_o;

    modport master (
        output req_i, we_i, funct3_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, funct3_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Word-organised data RAM behind a req/gnt/rvalid handshake with programmable response latency.
// Optional macro DMEM_ERR_EN: flag misaligned/reserved accesses on err_o and suppress them.
module riscv_dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    riscv_dmem_responder_if.slave bus
);
    // state | meaning
    // IDLE  | gnt_o high, waiting for a request
    // BUSY  | request accepted, counting down to the rvalid_o pulse
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            accept;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [2:0]      f3;
    logic [1:0]      lane;
    logic [AW-1:0]   idx;
    logic            is_b, is_h, is_w, rsv, bad;
    logic [3:0]      be;
    logic [XLEN-1:0] wlanes;
    logic [XLEN-1:0] word_rd;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_data;
    logic            unused_addr;

    assign f3          = bus.funct3_i;
    assign lane        = bus.addr_i[1:0];
    assign idx         = bus.addr_i[AW+1:2];
    assign unused_addr = ^bus.addr_i[XLEN-1:AW+2];

    assign is_b = (f3[1:0] == 2'b00);
    assign is_h = (f3[1:0] == 2'b01);
    assign is_w = (f3 == 3'b010);
    assign rsv  = (f3 == 3'b011) || (f3[2:1] == 2'b11);

`ifdef DMEM_ERR_EN
    logic misalign;
    logic err_q;
    assign misalign   = (is_h && lane[0]) || (is_w && (lane != 2'b00));
    assign bad        = rsv || misalign;
    assign bus.err_o  = err_q;
`else
    assign bad        = rsv;
    assign bus.err_o  = 1'b0;
`endif

    assign accept = (state_q == IDLE) && bus.req_i;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus.gnt_o    = 1'b0;
        bus.rvalid_o = 1'b0;
        case (state_q)
            IDLE: begin
                bus.gnt_o = 1'b1;
                if (bus.req_i) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    bus.rvalid_o = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte enables; a half access uses only addr[1], so misaligned halves land on the enclosing half
    always_comb begin
        be = 4'b0000;
        if (!bad) begin
            if (is_b)      be = 4'b0001 << lane;
            else if (is_h) be = lane[1] ? 4'b1100 : 4'b0011;
            else if (is_w) be = 4'b1111;
        end
    end

    always_comb begin
        wlanes = bus.wdata_i;
        if (is_b)      wlanes = {4{bus.wdata_i[7:0]}};
        else if (is_h) wlanes = {2{bus.wdata_i[15:0]}};
    end

    assign word_rd  = mem[idx];
    assign half_sel = lane[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        byte_sel = word_rd[7:0];
        case (lane)
            2'b01:   byte_sel = word_rd[15:8];
            2'b10:   byte_sel = word_rd[23:16];
            2'b11:   byte_sel = word_rd[31:24];
            default: byte_sel = word_rd[7:0];
        endcase
    end

    always_comb begin
        ld_data = '0;
        if (!bad) begin
            case (f3)
                3'b000:  ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                3'b100:  ld_data = {{(XLEN-8){1'b0}}, byte_sel};
                3'b001:  ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
                3'b101:  ld_data = {{(XLEN-16){1'b0}}, half_sel};
                3'b010:  ld_data = word_rd;
                default: ld_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && accept && bus.we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) rdata_q <= bus.we_i ? '0 : ld_data;
        end
    end

`ifdef DMEM_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)       err_q <= 1'b0;
        else if (accept) err_q <= bad;
    end
`endif

    assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Randomised bench for riscv_dmem_responder against a byte-addressed memory model.
module tb_riscv_dmem_responder;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model_mem [4096];

    always #5 clk = ~clk;

    riscv_dmem_responder_if #(.XLEN(32)) bus ();

    riscv_dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int sz;
        logic [11:0] a, base;
        bit rsv, mis;
        a   = addr[11:0];
        rsv = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        rd  = '0;
        er  = 1'b0;
`ifdef DMEM_ERR_EN
        if (rsv || mis) begin
            er = 1'b1;
            return;
        end
`endif
        if (rsv) return;
        base = a & ~12'(sz - 1);
        if (we) begin
            for (int i = 0; i < sz; i++) model_mem[base + 12'(i)] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < sz; i++) rd[8*i +: 8] = model_mem[base + 12'(i)];
            if (!f3[2] && sz == 1) rd = {{24{rd[7]}}, rd[7:0]};
            if (!f3[2] && sz == 2) rd = {{16{rd[15]}}, rd[15:0]};
        end
    endfunction

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit junk,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int waited, output bit gnt_bad);
        lat = -1; waited = -1; gnt_bad = 0; rdata = '0; err = 1'b0;
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = we; bus.funct3_i = f3; bus.addr_i = addr; bus.wdata_i = wdata;
        for (int i = 0; i < 20; i++) begin
            if (bus.gnt_o === 1'b1) begin
                waited = i;
                break;
            end
            @(negedge clk);
        end
        if (waited < 0) begin
            bus.req_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (junk) begin
            bus.we_i = 1'($urandom); bus.funct3_i = 3'($urandom);
            bus.addr_i = $urandom; bus.wdata_i = $urandom;
        end else begin
            bus.req_i = 1'b0;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.gnt_o !== 1'b0) gnt_bad = 1;
            if (bus.rvalid_o === 1'b1) begin
                lat = k; rdata = bus.rdata_o; err = bus.err_o;
                break;
            end
        end
        bus.req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = 3'b010; bus.addr_i = '0; bus.wdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.gnt_o !== 1'b1) begin miscompares++; $display("FAIL reset_gnt got %b want 1", bus.gnt_o); end
        vectors++; if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid_o); end
        vectors++; if (bus.rdata_o !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", bus.rdata_o); end
        vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.err_o); end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } dvec_t;

    task automatic test_directed();
        dvec_t v [8];
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat, waited;
        bit gb;
        v[0] = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0};
        v[1] = '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF};
        v[2] = '{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE};
        v[3] = '{1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE};
        v[4] = '{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD};
        v[5] = '{1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF};
        v[6] = '{1'b1, 3'b000, 32'h11, 32'h55, 32'h0};
        v[7] = '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF};
        foreach (v[i]) begin
            model(v[i].we, v[i].f3, v[i].addr, v[i].wdata, mrd, mer);
            xact(v[i].we, v[i].f3, v[i].addr, v[i].wdata, 1'b0, rd, er, lat, waited, gb);
            vectors++; if (lat != LAT) begin miscompares++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, LAT); end
            vectors++; if (rd !== v[i].exp) begin miscompares++; $display("FAIL directed%0d_rdata got %h want %h", i, rd, v[i].exp); end
            vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL directed%0d_err got %b want 0", i, er); end
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat, waited;
        bit gb;
        model(1'b0, 3'b010, 32'h10, 32'h0, mrd, mer);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rd, er, lat, waited, gb);
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL hold_latency got %0d want %0d", lat, LAT); end
        vectors++; if (gb) begin miscompares++; $display("FAIL hold_gnt_low got high want low while busy"); end
        vectors++; if (rd !== 32'hDEAD55EF) begin miscompares++; $display("FAIL hold_rdata got %h want DEAD55EF", rd); end
        @(negedge clk);
        vectors++; if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rvalid_pulse got %b want 0", bus.rvalid_o); end
        vectors++; if (bus.gnt_o !== 1'b1) begin miscompares++; $display("FAIL gnt_return got %b want 1", bus.gnt_o); end
    endtask

    task automatic test_rst_mid_busy();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat, waited;
        bit gb, seen;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus.req_i = 1'b1; bus.we_i = 1'(t); bus.funct3_i = 3'b010;
            bus.addr_i = (t == 0) ? 32'h10 : 32'h20; bus.wdata_i = 32'hA5A5_0F0F;
            if (t == 1) model(1'b1, 3'b010, 32'h20, 32'hA5A5_0F0F, mrd, mer);
            @(posedge clk);
            #1 bus.req_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            vectors++; if (bus.gnt_o !== 1'b1) begin miscompares++; $display("FAIL midrst%0d_gnt got %b want 1", t, bus.gnt_o); end
            vectors++; if (bus.rdata_o !== 32'h0) begin miscompares++; $display("FAIL midrst%0d_rdata got %h want 0", t, bus.rdata_o); end
            vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL midrst%0d_err got %b want 0", t, bus.err_o); end
            seen = 0;
            for (int k = 0; k < 8; k++) begin
                if (bus.rvalid_o !== 1'b0) seen = 1;
                @(negedge clk);
            end
            vectors++; if (seen) begin miscompares++; $display("FAIL midrst%0d_dropped got rvalid want none", t); end
        end
        model(1'b0, 3'b010, 32'h10, 32'h0, mrd, mer);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat, waited, gb);
        vectors++; if (rd !== mrd) begin miscompares++; $display("FAIL midrst_lw10 got %h want %h", rd, mrd); end
        model(1'b0, 3'b010, 32'h20, 32'h0, mrd, mer);
        xact(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, er, lat, waited, gb);
        vectors++; if (rd !== 32'hA5A5_0F0F) begin miscompares++; $display("FAIL midrst_store_kept got %h want A5A50F0F", rd); end
    endtask

    task automatic test_err();
        logic [31:0] rd, mrd, exp_word;
        logic er, mer, exp_err;
        int lat, waited;
        bit gb;
`ifdef DMEM_ERR_EN
        exp_err = 1'b1; exp_word = 32'hDEAD55EF;
`else
        exp_err = 1'b0; exp_word = 32'h00000001;
`endif
        model(1'b1, 3'b010, 32'h12, 32'h1, mrd, mer);
        xact(1'b1, 3'b010, 32'h12, 32'h1, 1'b0, rd, er, lat, waited, gb);
        vectors++; if (er !== exp_err) begin miscompares++; $display("FAIL err_sw12 got %b want %b", er, exp_err); end
        model(1'b0, 3'b010, 32'h10, 32'h0, mrd, mer);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat, waited, gb);
        vectors++; if (rd !== exp_word) begin miscompares++; $display("FAIL err_lw10 got %h want %h", rd, exp_word); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL err_lw10_err got %b want 0", er); end
        model(1'b0, 3'b011, 32'h10, 32'h0, mrd, mer);
        xact(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, rd, er, lat, waited, gb);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reserved_load got %h want 0", rd); end
        vectors++; if (er !== mer) begin miscompares++; $display("FAIL reserved_err got %b want %b", er, mer); end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, addr, wd;
        logic er, mer, we;
        logic [2:0] f3;
        int lat, waited;
        bit gb;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model(1'b1, 3'b010, 32'(4 * w), wd, mrd, mer);
            xact(1'b1, 3'b010, 32'(4 * w), wd, 1'b0, rd, er, lat, waited, gb);
        end
        for (int n = 0; n < 200; n++) begin
            we   = 1'($urandom);
            f3   = 3'($urandom);
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            wd   = $urandom;
            model(we, f3, addr, wd, mrd, mer);
            xact(we, f3, addr, wd, n[0], rd, er, lat, waited, gb);
            vectors++; if (lat != LAT) begin miscompares++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, LAT); end
            vectors++; if (gb) begin miscompares++; $display("FAIL rand%0d_gnt got high want low while busy", n); end
            vectors++; if (rd !== mrd) begin miscompares++; $display("FAIL rand%0d_rdata we=%b f3=%b addr=%h got %h want %h", n, we, f3, addr, rd, mrd); end
            vectors++; if (er !== mer) begin miscompares++; $display("FAIL rand%0d_err got %b want %b", n, er, mer); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, mrd, addr;
        logic er, mer;
        int lat, waited;
        bit gb;
        for (int n = 0; n < 10; n++) begin
            addr = 32'($urandom_range(0, 15)) << 2;
            model(1'b0, 3'b010, addr, 32'h0, mrd, mer);
            xact(1'b0, 3'b010, addr, 32'h0, 1'b1, rd, er, lat, waited, gb);
            vectors++; if (waited != 0) begin miscompares++; $display("FAIL b2b%0d_wait got %0d want 0", n, waited); end
            vectors++; if (lat != LAT) begin miscompares++; $display("FAIL b2b%0d_latency got %0d want %0d", n, lat, LAT); end
            vectors++; if (rd !== mrd) begin miscompares++; $display("FAIL b2b%0d_rdata got %h want %h", n, rd, mrd); end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_rst_mid_busy();
        test_err();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
